// File: rtl/sprite_pkg.sv
// Shared types, defaults and pixel format helpers for the sprite blitter.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_SPRITE_W = 8;
    localparam int unsigned DEF_SPRITE_H = 16;
    localparam int unsigned DEF_FB_W     = 240;
    localparam int unsigned DEF_FB_H     = 320;

    localparam logic [23:0] DEF_TRANS_KEY = 24'hFFFFFF;

    // Truncate each RGB888 channel to its RGB565 field width.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major row/column scan counter over the sprite bitmap.
module sprite_scan_counter
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H = DEF_SPRITE_H,
    parameter int unsigned CW       = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
    parameter int unsigned RW       = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic col_end;

    assign col_end = (col == CW'(SPRITE_W - 1));
    assign last    = col_end && (row == RW'(SPRITE_H - 1));

    // Wrap back to the origin after the last pixel so the counters stay in range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Scans the sprite bitmap and streams visible, on-screen pixels as RGB565 writes.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W  = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H  = DEF_SPRITE_H,
    parameter int unsigned FB_W      = DEF_FB_W,
    parameter int unsigned FB_H      = DEF_FB_H,
    parameter logic [23:0] TRANS_KEY = DEF_TRANS_KEY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  xpos,
    input  logic [8:0]  ypos,
    output logic        busy,
    output logic        done,
    output logic [15:0] bm_yofs,
    output logic [15:0] bm_xofs,
    input  logic [23:0] bm_pixel,
    output logic [7:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready
);

    localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    state_t        state;
    logic [7:0]    xpos_q;
    logic [8:0]    ypos_q;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last;
    logic          clear;
    logic          advance;
    logic [9:0]    sx;
    logic [9:0]    sy;
    logic          skip;

    sprite_scan_counter #(
        .SPRITE_W(SPRITE_W),
        .SPRITE_H(SPRITE_H),
        .CW      (CW),
        .RW      (RW)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .advance(advance),
        .col    (col),
        .row    (row),
        .last   (last)
    );

    assign bm_yofs = 16'(row);
    assign bm_xofs = 16'(col);

    // 10-bit sums so positions past the screen edge compare as off-screen instead of wrapping.
    assign sx   = 10'(xpos_q) + 10'(col);
    assign sy   = 10'(ypos_q) + 10'(row);
    assign skip = (bm_pixel == TRANS_KEY) || (sx >= 10'(FB_W)) || (sy >= 10'(FB_H));

    assign clear   = (state == IDLE) && start;
    assign advance = ((state == FETCH) && skip) || ((state == EMIT) && pix_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            xpos_q    <= '0;
            ypos_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xpos_q <= xpos;
                        ypos_q <= ypos;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (skip) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        pix_x     <= sx[7:0];
                        pix_y     <= sy[8:0];
                        pix_data  <= rgb888_to_565(bm_pixel);
                        pix_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    pix_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Reader side of the sprite bitmap ROM. On a `start` pulse it scans every pixel of the sprite bitmap and pushes each visible pixel to the LT24 framebuffer writer as an RGB565 write.
- It addresses the bitmap through `bm_yofs`/`bm_xofs` and receives 24-bit RGB888 on `bm_pixel`.
- It drops transparent-key pixels and pixels that fall off the screen.
- Writes go out on a valid/ready stream.

## Interface
- `SPRITE_W`, default 8: bitmap columns.
- `SPRITE_H`, default 16: bitmap rows.
- `FB_W`, default 240: screen width in pixels.
- `FB_H`, default 320: screen height in pixels.
- `TRANS_KEY`, default 24'hFFFFFF: RGB888 value treated as transparent.
- `clock`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a blit; sampled only in IDLE.
- `xpos`  in  8: screen x of sprite column 0; latched on start.
- `ypos`  in  9: screen y of sprite row 0; latched on start.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the blit completes.
- `bm_yofs`  out  16: bitmap row index, 0..SPRITE_H-1.
- `bm_xofs`  out  16: bitmap column index, 0..SPRITE_W-1.
- `bm_pixel`  in  24: combinational RGB888 bitmap data for the current offsets.
- `pix_x`  out  8: screen x of the write.
- `pix_y`  out  9: screen y of the write.
- `pix_data`  out  16: RGB565 value of the write.
- `pix_valid`  out  1: write request.
- `pix_ready`  in  1: framebuffer writer accepts the write.

## Operation
- The FSM states are IDLE, FETCH, EMIT and DONE.
- **IDLE:**
  - `start`=1 latches `xpos`/`ypos`, clears the row and column counters, and moves to FETCH.
  - `start` is ignored in every other state.
- **FETCH:**
  - `bm_yofs`/`bm_xofs` equal the counters, zero-extended.
  - `bm_pixel` is registered in this cycle.
  - Screen coordinates: sx = xpos + col and sy = ypos + row, each computed at 10 bits with no wrap.
  - Skip condition: `bm_pixel`==TRANS_KEY, or sx ≥ FB_W, or sy ≥ FB_H.
  - On skip, advance the counters and stay in FETCH, or go to DONE if this was the last pixel.
  - Otherwise load `pix_x`=sx[7:0], `pix_y`=sy[8:0] and `pix_data`={R[7:3],G[7:2],B[7:3]}, then go to EMIT.
- **EMIT:**
  - `pix_valid`=1, and `pix_x`/`pix_y`/`pix_data` are held stable until `pix_ready`=1.
  - On handshake, advance the counters and go to FETCH, or to DONE if this was the last pixel.
- **Advance:** when col==SPRITE_W-1, set col=0 and increment row; otherwise increment col. The last pixel is row==SPRITE_H-1 and col==SPRITE_W-1.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Scan order:** row-major, row 0 first, col 0 first within each row.
- **Reset values:**
  - state=IDLE.
  - `busy`, `done` and `pix_valid` are 0.
  - `pix_x`, `pix_y`, `pix_data`, `bm_yofs` and `bm_xofs` are 0.
  - Latched position is 0.
- **Reset mid-blit:** aborts immediately and asynchronously. `pix_valid` drops without a handshake, no `done` pulse is produced, and the next `start` begins a fresh blit.

## Timing
- Cycle 1 is the first cycle after the edge that samples `start`; the FSM is in FETCH there.
- A skipped pixel costs 1 cycle.
- A drawn pixel costs 2 cycles when `pix_ready` is held high, plus one cycle per cycle that `pix_ready` is low in EMIT.
- With `pix_ready` tied high, `done` is high in cycle 2·D + S + 1, where D is drawn pixels and S is skipped pixels.
- `pix_valid` is registered: it never depends combinationally on `pix_ready`.
- No new write appears in the cycle after a handshake; that cycle is always FETCH.
- `busy` rises in cycle 1 and falls in the cycle after `done`.

## Structure
- **Package `sprite_pkg`:**
  - state enum.
  - SPRITE_W/SPRITE_H/FB_W/FB_H defaults.
  - TRANS_KEY.
  - function rgb888_to_565.
- **Sub-module `sprite_scan_counter`:** the row/column counters with clear, advance and last outputs. This is the one natural split; keep the FSM in the top module.
- The bitmap ROM stays outside this block and is wired at the top level.

## Test plan
- **Full default blit:**
  - Stimulus: xpos=0, ypos=0, `pix_ready`=1.
  - 40 pixels are FFFFFF and are skipped, so exactly 88 writes occur.
  - Every `pix_data` is 16'hF81F (for FF00FF) or 16'h0000 (for 000000).
  - `done` appears in cycle 217 and `busy` falls at cycle 218.
- **Right-edge clipping:**
  - Stimulus: xpos=236, ypos=0.
  - No write has `pix_x` ≥ 240.
  - Columns 4–7 are skipped in every row.
  - `done` still pulses once.
- **Backpressure:**
  - Stimulus: hold `pix_ready`=0 for 5 cycles on the first write.
  - `pix_valid` stays 1 throughout and `pix_x`/`pix_y`/`pix_data` stay unchanged.
  - The write completes on the cycle `pix_ready` rises.
- **Start while busy:**
  - Stimulus: pulse `start` with xpos=100 during a blit at xpos=0.
  - It is ignored: all writes use the original position and exactly one `done` pulse occurs.
- **Reset mid-blit:**
  - Stimulus: assert `reset` in EMIT.
  - `pix_valid`, `busy` and `bm_yofs` are 0 immediately.
  - A following `start` with xpos=10, ypos=20 produces its first write at (13,20).
- **Bottom clipping:**
  - Stimulus: ypos=310.
  - Rows 10–15 produce no writes.
  - The last write has `pix_y`=319.
